circle_sweep: RTL and testbench
===============================

# circle_sweep

Request-side sequencer for the `circle_1024` point generator. It walks an angle from a start value by a fixed step and issues one req/ack transaction per point with the latched radius and centre. It buffers each returned (x, y) in a small FIFO and presents the points on a valid/ready stream toward the deflection/DAC output path. It is the initiator counterpart to the circle responder and replaces bench-driven angle stepping in the real design.

## Interface
- `ANGLE_W`, default 10: angle width; the angle wraps modulo 2^ANGLE_W.
- `COORD_W`, default 8: width of r, x0, y0, x, y.
- `DEPTH`, default 4: point FIFO depth, power of two, ≥ 2.

- `clock`  in  1  single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `stop`  in  1  level; ends the sweep after the in-flight transaction.
- `start_angle`  in  ANGLE_W  first angle.
- `step`  in  ANGLE_W  angle increment per point.
- `count`  in  16  number of points; 0 means continuous until `stop`.
- `r`, `x0`, `y0`  in  COORD_W each  circle parameters, latched on start.
- `req_o`  out  1  request to responder.
- `angle_o`  out  ANGLE_W  request angle.
- `r_o`, `x0_o`, `y0_o`  out  COORD_W each  latched parameters.
- `ack_i`  in  1  responder acknowledge.
- `x_i`, `y_i`  in  COORD_W each  result, valid in the ack cycle.
- `pt_valid`, `pt_x`, `pt_y`  out  1/COORD_W/COORD_W  point stream.
- `pt_ready`  in  1  downstream accept.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start` latches r, x0, y0, step, count into registers and loads angle with start_angle and remaining with count, then goes to RUN.
- RUN: `req_o` asserts only when the FIFO has at least one free slot, counting the push of the ack in the same cycle. One transaction is outstanding at most. `angle_o`, `r_o`, `x0_o`, `y0_o` stay stable while `req_o` is high.
- Once raised, `req_o` stays high until `ack_i` is sampled high. It never drops early.
- An edge with `req_o && ack_i` does the following:
  - push {x_i, y_i};
  - angle ← angle + step (mod 2^ANGLE_W);
  - if count ≠ 0, remaining ← remaining − 1.
- At that ack, the block goes to DRAIN if remaining reaches 0 or `stop` is high. Otherwise it stays in RUN and may keep `req_o` high back-to-back.
- `stop` raised between acks takes effect at the next ack. `stop` is ignored in IDLE.
- DRAIN: `req_o` is 0. When the FIFO is empty, pulse `done` and go to IDLE.
- `ack_i` while `req_o` is low is ignored: no push and no state change.
- `start` outside IDLE is ignored.
- FIFO: `pt_valid` = not empty. A pop occurs on `pt_valid && pt_ready`. Simultaneous push and pop are legal in any state, including full with a pop.

## Timing
- Reset state: all outputs 0, state IDLE, FIFO empty, angle 0.
- `start` sampled at edge N gives `req_o` = 1 with `angle_o` = start_angle from after edge N.
- Ack sampled at edge M:
  - the point is visible on `pt_valid`/`pt_x`/`pt_y` after M (FIFO write-to-read latency 1);
  - the new `angle_o` is valid after M.
  - `req_o` after M is 1 only if RUN continues and (FIFO level after M) < DEPTH.
- With `pt_ready` held at 1 and a zero-wait responder (ack in the first req cycle), throughput is one point per cycle.
- `done` is asserted one cycle after the FIFO becomes empty in DRAIN. `busy` falls with that same edge.
- The asynchronous reset clears everything immediately, including mid-transaction. After reset release the block is in IDLE, and a stray `ack_i` has no effect.

## Structure
- `lissajous_pkg` holds:
  - the `ANGLE_W` and `COORD_W` defaults;
  - `point_t` packed struct {x, y};
  - `sweep_state_t` enum {IDLE, RUN, DRAIN}.
- Sub-module `point_fifo`: synchronous FIFO of `point_t` with parameter DEPTH. It exposes level/full/empty, with registered read data and a first-word latency of 1.
- Top holds the FSM, the angle/remaining counters and the req logic.

## Test plan
1. **Basic sweep.** start_angle=0, step=1, count=4, r=120, x0=120, y0=128; responder acks 2 cycles after req; `pt_ready`=1.
   - `angle_o` sequence is 0,1,2,3; exactly 4 acks and 4 points in order; `done` pulses once; `busy` falls.
2. **Backpressure.** DEPTH=4, `pt_ready`=0, count=8.
   - Exactly 4 acks, then `req_o` stays 0.
   - After `pt_ready`=1, the remaining 4 points complete; no req/ack overlap violation occurs.
3. **Wrap-around.** start_angle=1022, step=3, count=3.
   - `angle_o` sequence is 1022, 1, 4.
4. **Continuous with stop.** count=0; `stop` asserted 1 cycle after the 5th ack, while req is high.
   - The 6th ack completes; no 7th req; FIFO drains; `done` pulses.
5. **Reset mid-transaction.** `reset` falls while `req_o` is high.
   - All outputs go to 0 without waiting for a clock edge.
   - After release, an injected `ack_i` produces no point; a new `start` runs normally.
6. **Start while busy.** `start` pulsed with start_angle=500 mid-sweep.
   - Ignored: the sweep continues with the original angles and count.

Source files
------------

// File: rtl/lissajous_pkg.sv
// Shared types for the circle sweep sequencer and its point FIFO.
// No logic here: widths, the point record and the sweep state encoding.
// Consumers import with lissajous_pkg::*.
package lissajous_pkg;
   localparam int DEF_ANGLE_W = 10;
   localparam int DEF_COORD_W = 8;

   typedef struct packed {
      logic [DEF_COORD_W-1:0] x;
      logic [DEF_COORD_W-1:0] y;
   } point_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} sweep_state_t;
endpackage

// File: rtl/point_fifo.sv
// Synchronous FIFO of point_t with level/full/empty status.
// Latency: a push is visible on rdat/empty one cycle later; read data is registered.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module point_fifo
   import lissajous_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  point_t                   wdat,
   input  logic                     pop,
   output point_t                   rdat,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   point_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;
   logic [AW:0]     remain;

   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign remain  = level - {{AW{1'b0}}, do_pop};

   // storage array, written at the tail
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdat;
   end

   // pointers, occupancy and the registered head-of-queue word
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         rdat   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
         // a push into an (effectively) empty queue bypasses the array
         if (do_push && remain == '0) rdat <= wdat;
         else if (do_pop)             rdat <= mem[rd_ptr + 1'b1];
      end
   end
endmodule

// File: rtl/circle_sweep.sv
// Angle sweep initiator: one req/ack per point, results buffered to a valid/ready stream.
// Latency: start -> req next cycle; ack -> point on pt_valid and next angle next cycle.
// Backpressure: req is withheld while the point FIFO has no free slot for the result.
module circle_sweep
   import lissajous_pkg::*;
#(
   parameter int ANGLE_W = DEF_ANGLE_W,
   parameter int COORD_W = DEF_COORD_W,
   parameter int DEPTH   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic [ANGLE_W-1:0] start_angle,
   input  logic [ANGLE_W-1:0] step,
   input  logic [15:0]        count,
   input  logic [COORD_W-1:0] r,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   output logic               req_o,
   output logic [ANGLE_W-1:0] angle_o,
   output logic [COORD_W-1:0] r_o,
   output logic [COORD_W-1:0] x0_o,
   output logic [COORD_W-1:0] y0_o,
   input  logic               ack_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   output logic               pt_valid,
   output logic [COORD_W-1:0] pt_x,
   output logic [COORD_W-1:0] pt_y,
   input  logic               pt_ready,
   output logic               busy,
   output logic               done
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   sweep_state_t        state;
   logic [ANGLE_W-1:0]  step_q;
   logic [15:0]         remaining;
   logic                cont_q;

   logic                push;
   logic                pop;
   point_t              wdat;
   point_t              rdat;
   logic [LW-1:0]       level;
   logic [LW-1:0]       level_next;
   logic                full;
   logic                empty;
   logic                room_after_ack;
   logic                room_no_ack;
   logic                last_pt;

   // an ack only counts while a request is outstanding
   assign push     = req_o && ack_i;
   assign pop      = pt_valid && pt_ready;
   assign wdat     = '{x: x_i, y: y_i};
   assign pt_valid = !empty;
   assign pt_x     = rdat.x;
   assign pt_y     = rdat.y;
   assign busy     = (state != IDLE);

   assign level_next     = level + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
   assign room_after_ack = (level_next < FULL_LVL);
   assign room_no_ack    = !full || pop;
   assign last_pt        = !cont_q && (remaining == 16'd1);

   point_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .wdat  (wdat),
      .pop   (pop),
      .rdat  (rdat),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // sweep FSM with registered request, angle/remaining counters and done pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         req_o     <= 1'b0;
         angle_o   <= '0;
         r_o       <= '0;
         x0_o      <= '0;
         y0_o      <= '0;
         step_q    <= '0;
         remaining <= '0;
         cont_q    <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  req_o     <= 1'b1;
                  angle_o   <= start_angle;
                  r_o       <= r;
                  x0_o      <= x0;
                  y0_o      <= y0;
                  step_q    <= step;
                  remaining <= count;
                  cont_q    <= (count == 16'd0);
               end
            end
            RUN: begin
               if (push) begin
                  angle_o <= angle_o + step_q;
                  if (!cont_q) remaining <= remaining - 16'd1;
                  if (last_pt || stop) begin
                     state <= DRAIN;
                     req_o <= 1'b0;
                  end else begin
                     req_o <= room_after_ack;
                  end
               end else if (!req_o) begin
                  // raised request is held until acked; only re-arm from low
                  req_o <= room_no_ack;
               end
            end
            DRAIN: begin
               if (empty) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               req_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_circle_sweep.sv
// Directed bench for circle_sweep: bench acts as the circle responder and the stream sink.
// Expected angles are queued per test; each accepted request queues its expected point.
// A monitor pops the point queue whenever the stream hands over a point.
module tb_circle_sweep;
   import lissajous_pkg::*;

   localparam int AW    = 10;
   localparam int CW    = 8;
   localparam int DEPTH = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          start, stop;
   logic [AW-1:0] start_angle, step;
   logic [15:0]   count;
   logic [CW-1:0] r, x0, y0;
   logic          req_o;
   logic [AW-1:0] angle_o;
   logic [CW-1:0] r_o, x0_o, y0_o;
   logic          ack_i;
   logic [CW-1:0] x_i, y_i;
   logic          pt_valid;
   logic [CW-1:0] pt_x, pt_y;
   logic          pt_ready;
   logic          busy, done;

   always #5 clock = ~clock;

   circle_sweep #(.ANGLE_W(AW), .COORD_W(CW), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop),
      .start_angle(start_angle), .step(step), .count(count),
      .r(r), .x0(x0), .y0(y0),
      .req_o(req_o), .angle_o(angle_o), .r_o(r_o), .x0_o(x0_o), .y0_o(y0_o),
      .ack_i(ack_i), .x_i(x_i), .y_i(y_i),
      .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_ready(pt_ready),
      .busy(busy), .done(done)
   );

   int checks = 0;
   int errors = 0;
   int acks   = 0;
   int points = 0;
   int dones  = 0;

   logic [AW-1:0]   exp_ang [$];
   logic [2*CW-1:0] exp_pt  [$];

   int            ack_wait = 2;
   bit            rsp_en   = 1'b0;
   bit            in_txn   = 1'b0;
   int            rcnt     = 0;
   logic [AW-1:0] cur_ang;
   logic [CW-1:0] exp_r, exp_x0, exp_y0;

   // responder data mapping: x = angle low byte, y = angle/4 low byte
   function automatic logic [2*CW-1:0] pt_of(input logic [AW-1:0] a);
      logic [AW-1:0] s;
      s = a >> 2;
      return {a[CW-1:0], s[CW-1:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // responder: accepts one request at a time, acks after ack_wait cycles
   initial begin
      logic [AW-1:0] e;
      ack_i = 1'b0;
      x_i   = '0;
      y_i   = '0;
      forever begin
         @(negedge clock);
         if (rsp_en) begin
            if (ack_i) begin
               ack_i  = 1'b0;
               in_txn = 1'b0;
            end else if (req_o) begin
               if (!in_txn) begin
                  in_txn  = 1'b1;
                  rcnt    = 0;
                  cur_ang = angle_o;
                  if (exp_ang.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_req: got angle %0d, expected no request", angle_o);
                  end else begin
                     e = exp_ang.pop_front();
                     chk("req_angle", 32'(angle_o), 32'(e));
                     exp_pt.push_back(pt_of(e));
                  end
                  chk("req_r",  32'(r_o),  32'(exp_r));
                  chk("req_x0", 32'(x0_o), 32'(exp_x0));
                  chk("req_y0", 32'(y0_o), 32'(exp_y0));
               end else begin
                  chk("req_angle_stable", 32'(angle_o), 32'(cur_ang));
               end
               if (rcnt >= ack_wait) begin
                  ack_i      = 1'b1;
                  {x_i, y_i} = pt_of(angle_o);
                  acks++;
               end else begin
                  rcnt++;
               end
            end else if (in_txn) begin
               checks++;
               errors++;
               $display("FAIL req_dropped: got req 0 expected 1 before ack");
               in_txn = 1'b0;
            end
         end
      end
   end

   // stream monitor and done counter
   always @(negedge clock) begin
      if (done) dones++;
      if (pt_valid && pt_ready) begin
         if (exp_pt.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_point: got %0d,%0d expected none", pt_x, pt_y);
         end else begin
            chk("point", 32'({pt_x, pt_y}), 32'(exp_pt.pop_front()));
         end
         points++;
      end
   end

   task automatic go(input logic [AW-1:0] sa, input logic [AW-1:0] st, input logic [15:0] cnt,
                     input logic [CW-1:0] rr, input logic [CW-1:0] xx, input logic [CW-1:0] yy);
      @(posedge clock); #1;
      start_angle = sa; step = st; count = cnt;
      r = rr; x0 = xx; y0 = yy;
      exp_r = rr; exp_x0 = xx; exp_y0 = yy;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(posedge clock); #1;
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s_timeout: got busy 1 expected 0 within %0d cycles", name, budget);
      end
      repeat (2) begin @(posedge clock); #1; end
   endtask

   task automatic push_angles(input logic [AW-1:0] a0, input logic [AW-1:0] st, input int n);
      logic [AW-1:0] a;
      a = a0;
      for (int i = 0; i < n; i++) begin
         exp_ang.push_back(a);
         a = a + st;
      end
   endtask

   initial begin
      int a0, p0, d0, n;
      reset = 1'b0; start = 1'b0; stop = 1'b0; pt_ready = 1'b1;
      start_angle = '0; step = '0; count = '0; r = '0; x0 = '0; y0 = '0;
      exp_r = '0; exp_x0 = '0; exp_y0 = '0;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_req",   32'(req_o), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_valid", 32'(pt_valid), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_angle", 32'(angle_o), 0);
      @(negedge clock);
      reset = 1'b1;

      // 1: basic sweep, responder waits 2 cycles
      rsp_en = 1'b1; ack_wait = 2;
      a0 = acks; p0 = points; d0 = dones;
      push_angles(10'd0, 10'd1, 4);
      go(10'd0, 10'd1, 16'd4, 8'd120, 8'd120, 8'd128);
      wait_idle("t1", 200);
      chk("t1_acks",   32'(acks - a0), 4);
      chk("t1_points", 32'(points - p0), 4);
      chk("t1_done",   32'(dones - d0), 1);
      chk("t1_busy",   32'(busy), 0);
      chk("t1_queues", 32'(exp_ang.size() + exp_pt.size()), 0);

      // 2: backpressure fills the FIFO, then drains
      ack_wait = 0; pt_ready = 1'b0;
      a0 = acks; p0 = points; d0 = dones;
      push_angles(10'd100, 10'd10, 8);
      go(10'd100, 10'd10, 16'd8, 8'd3, 8'd4, 8'd5);
      repeat (30) begin @(posedge clock); #1; end
      chk("t2_acks_full", 32'(acks - a0), 4);
      chk("t2_req_held",  32'(req_o), 0);
      chk("t2_valid",     32'(pt_valid), 1);
      chk("t2_no_pop",    32'(points - p0), 0);
      pt_ready = 1'b1;
      wait_idle("t2", 300);
      chk("t2_acks",   32'(acks - a0), 8);
      chk("t2_points", 32'(points - p0), 8);
      chk("t2_done",   32'(dones - d0), 1);

      // 3: angle wrap-around
      ack_wait = 1;
      a0 = acks; p0 = points;
      exp_ang.push_back(10'd1022);
      exp_ang.push_back(10'd1);
      exp_ang.push_back(10'd4);
      go(10'd1022, 10'd3, 16'd3, 8'd7, 8'd8, 8'd9);
      wait_idle("t3", 200);
      chk("t3_acks",   32'(acks - a0), 3);
      chk("t3_points", 32'(points - p0), 3);

      // 4: continuous sweep, stop one cycle after the 5th ack
      ack_wait = 1;
      a0 = acks; p0 = points; d0 = dones;
      push_angles(10'd0, 10'd5, 6);
      go(10'd0, 10'd5, 16'd0, 8'd11, 8'd12, 8'd13);
      n = 0;
      while ((acks - a0) < 5 && n < 200) begin @(posedge clock); #1; n++; end
      chk("t4_five_acks", 32'(acks - a0), 5);
      @(posedge clock); #1;
      chk("t4_req_at_stop", 32'(req_o), 1);
      stop = 1'b1;
      wait_idle("t4", 200);
      stop = 1'b0;
      chk("t4_acks",   32'(acks - a0), 6);
      chk("t4_points", 32'(points - p0), 6);
      chk("t4_done",   32'(dones - d0), 1);

      // 5: asynchronous reset mid-transaction
      rsp_en = 1'b0;
      go(10'd7, 10'd1, 16'd3, 8'd21, 8'd22, 8'd23);
      repeat (2) begin @(posedge clock); #1; end
      chk("t5_req_before", 32'(req_o), 1);
      #3 reset = 1'b0;
      #1;
      chk("t5_req",   32'(req_o), 0);
      chk("t5_busy",  32'(busy), 0);
      chk("t5_angle", 32'(angle_o), 0);
      chk("t5_r",     32'(r_o), 0);
      chk("t5_valid", 32'(pt_valid), 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      ack_i = 1'b1; x_i = 8'hAA; y_i = 8'h55;
      @(posedge clock); #1;
      ack_i = 1'b0;
      repeat (3) begin @(posedge clock); #1; end
      chk("t5_stray_valid", 32'(pt_valid), 0);
      chk("t5_stray_busy",  32'(busy), 0);
      rsp_en = 1'b1; ack_wait = 1;
      a0 = acks; p0 = points; d0 = dones;
      exp_ang.push_back(10'd300);
      exp_ang.push_back(10'd307);
      go(10'd300, 10'd7, 16'd2, 8'd31, 8'd32, 8'd33);
      wait_idle("t5", 200);
      chk("t5_acks",   32'(acks - a0), 2);
      chk("t5_points", 32'(points - p0), 2);
      chk("t5_done",   32'(dones - d0), 1);

      // 6: start while busy is ignored
      ack_wait = 2;
      a0 = acks; p0 = points; d0 = dones;
      push_angles(10'd200, 10'd2, 3);
      go(10'd200, 10'd2, 16'd3, 8'd50, 8'd60, 8'd70);
      repeat (2) begin @(posedge clock); #1; end
      start_angle = 10'd500; count = 16'd1; r = 8'd9; step = 10'd100;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_idle("t6", 200);
      chk("t6_acks",   32'(acks - a0), 3);
      chk("t6_points", 32'(points - p0), 3);
      chk("t6_done",   32'(dones - d0), 1);
      chk("t6_queues", 32'(exp_ang.size() + exp_pt.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end
endmodule
